buf_alloc: RTL and testbench
============================

Name: buf_alloc

Overview:
- Owns the router's seven message buffers and their 3-bit priority table: pri1..pri7, where 000 means free.
- Feeds the priority table to the free-buffer finder.
- Consumes the finder's four free-buffer indices (free1..free4) to grant buffers to up to four incoming message requests per cycle.
- Also handles buffer release and priority aging of waiting messages.

Parameters:
- AGE_PERIOD, 16: cycles between aging ticks; legal range 2..255.
- AGE_EN, 1: 1 enables aging of occupied buffers; 0 freezes priorities after allocation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- free1, free2, free3, free4  in  3 each  free-buffer indices from the finder; 0 = none, 1..7 = buffer number.
- req_valid  in  4  bit i: request i presents a message.
- req_pri  in  12  request i priority at bits [3i:3i+2]; must be nonzero.
- req_ready  out  4  bit i: request i accepted this cycle (combinational).
- grant_valid  out  4  registered; bit i: request i was granted last cycle.
- grant_buf  out  12  registered; buffer index granted to request i (3 bits each).
- rel_valid  in  1  release strobe.
- rel_buf  in  3  buffer to release, 1..7.
- pri1 .. pri7  out  3 each  registered buffer priority table; 000 = free.
- occ_count  out  3  registered count of nonzero priN entries, 0..7.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, rst_n low):
  - pri1..pri7 = 0; occ_count = 0.
  - grant_valid = 0; grant_buf = 0; err = 0.
  - Age counter = 0.
  - Takes effect immediately, mid-operation included; any in-flight grant is lost.
- Free-list compaction (combinational):
  - Nonzero freeN values are packed in order free1, free2, free3, free4 into slots s0..s3.
  - K = number of nonzero freeN.
- Request eligibility:
  - Request i is eligible when req_valid[i] = 1 and req_pri[i] != 0.
  - A zero priority makes the request ineligible: ready stays 0 and err is not set.
- Grant assignment (fixed priority, request 0 highest):
  - The j-th eligible request in order 0..3 gets slot s_j if j < K; otherwise its req_ready = 0.
  - req_ready is a combinational function of the inputs and the registered table only.
- Accept edge:
  - For each accepted request, pri[s_j] <= req_pri[i].
  - grant_valid[i] <= 1 and grant_buf[i] <= s_j.
  - For non-accepted requests, grant_valid[i] <= 0 and grant_buf[i] <= 0.
  - Latency: the table and grant outputs update 1 cycle after acceptance.
  - The finder sees new occupancy the following cycle; there is no same-cycle forwarding.
- Release:
  - At the edge with rel_valid = 1 and rel_buf in 1..7, pri[rel_buf] <= 0.
  - Releasing a buffer that is already free sets err and otherwise has no effect.
  - rel_buf = 0 with rel_valid = 1 sets err.
  - A released buffer becomes allocatable no earlier than the next cycle.
- Input consistency checks (err set, grants still issued from deduplicated slots):
  - Any freeN naming a buffer whose pri is nonzero: the offending slot is discarded.
  - Duplicate nonzero freeN values: only the first occurrence is used.
- Same-cycle release and allocation:
  - Both are applied; they target disjoint buffers, because allocation only uses free entries.
  - If a request targets rel_buf's old buffer, that slot was already discarded by the check above.
- Aging (AGE_EN = 1):
  - The age counter counts 0..AGE_PERIOD-1 and wraps.
  - On the wrap cycle every nonzero pri increments by 1, saturating at 7.
  - Buffers allocated or released in the same cycle take the allocate/release value; no increment is applied to them.
- occ_count: registered; equals the popcount of the next-state table.
- Full condition: with occ_count = 7 the finder yields all zeros, so K = 0 and all req_ready = 0.

Test Plan:
- Reset, then free1..4 = 1,2,3,4; req_valid = 1111; req_pri = 5,3,7,1.
  -> req_ready = 1111; next cycle grant_buf = 1,2,3,4, grant_valid = 1111, pri1..4 = 5,3,7,1, occ_count = 4.
- free = 0,6,0,7; req_valid = 1011.
  -> req0 gets 6, req2 gets 7, req3 ready = 0; pri6, pri7 loaded; grant_valid = 1010.
- Table full (occ_count = 7), rel_valid with rel_buf = 3, req_valid = 0001, free all 0.
  -> req_ready = 0 that cycle; next cycle pri3 = 0, occ_count = 6.
- rel_valid with rel_buf = 5 while pri5 = 0.
  -> err = 1 and stays set; table unchanged.
- AGE_PERIOD = 4; pri2 = 6 held 8 cycles with no release.
  -> pri2 = 7 after the first wrap and stays 7 after the second.
- Assert rst_n low mid-grant.
  -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/buf_alloc.sv
// Buffer allocator for the router's seven message buffers: grants free buffers to up to
// four requests per cycle, handles release, and ages the priority of occupied buffers.
module buf_alloc #(
    parameter int AGE_PERIOD = 16,
    parameter bit AGE_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  free1,
    input  logic [2:0]  free2,
    input  logic [2:0]  free3,
    input  logic [2:0]  free4,
    input  logic [3:0]  req_valid,
    input  logic [11:0] req_pri,
    output logic [3:0]  req_ready,
    output logic [3:0]  grant_valid,
    output logic [11:0] grant_buf,
    input  logic        rel_valid,
    input  logic [2:0]  rel_buf,
    output logic [2:0]  pri1,
    output logic [2:0]  pri2,
    output logic [2:0]  pri3,
    output logic [2:0]  pri4,
    output logic [2:0]  pri5,
    output logic [2:0]  pri6,
    output logic [2:0]  pri7,
    output logic [2:0]  occ_count,
    output logic        err
);

    localparam logic [7:0] AGE_LAST = 8'(AGE_PERIOD - 1);

    // Entry 0 is a permanently free, unused slot so that a 3-bit index can address the table directly.
    logic [2:0]  pri_reg [8];
    logic [2:0]  pri_next [8];
    logic [7:0]  age_reg;
    logic [3:0]  grant_valid_reg;
    logic [11:0] grant_buf_reg;
    logic [11:0] grant_buf_next;
    logic [2:0]  occ_reg;
    logic [2:0]  occ_next;
    logic        err_reg;

    logic [2:0]  free_in [4];
    logic [3:0]  slot_ok;
    logic        free_err;
    logic [2:0]  slot [4];
    logic [2:0]  slot_cnt;
    logic [3:0]  elig;
    logic [3:0]  ready;
    logic [2:0]  req_slot [4];
    logic        rel_hit;
    logic        rel_err;
    logic        age_wrap;

    assign free_in[0] = free1;
    assign free_in[1] = free2;
    assign free_in[2] = free3;
    assign free_in[3] = free4;

    // A finder entry is usable only if it names a free buffer not already named earlier.
    always_comb begin
        free_err = 1'b0;
        for (int n = 0; n < 4; n++) begin
            slot_ok[n] = 1'b0;
            if (free_in[n] != 3'd0) begin
                slot_ok[n] = (pri_reg[free_in[n]] == 3'd0);
                for (int m = 0; m < n; m++) begin
                    if (free_in[m] == free_in[n]) begin
                        slot_ok[n] = 1'b0;
                    end
                end
                if (!slot_ok[n]) begin
                    free_err = 1'b1;
                end
            end
        end
    end

    always_comb begin
        slot_cnt = 3'd0;
        for (int n = 0; n < 4; n++) begin
            slot[n] = 3'd0;
        end
        for (int n = 0; n < 4; n++) begin
            if (slot_ok[n]) begin
                slot[slot_cnt[1:0]] = free_in[n];
                slot_cnt            = slot_cnt + 3'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_req
            assign elig[gi] = req_valid[gi] && (req_pri[3*gi +: 3] != 3'd0);
            assign grant_buf_next[3*gi +: 3] = ready[gi] ? req_slot[gi] : 3'd0;
        end
    endgenerate

    // Eligible requests take packed slots in order, request 0 first.
    always_comb begin
        logic [2:0] used;
        used  = 3'd0;
        ready = 4'd0;
        for (int i = 0; i < 4; i++) begin
            req_slot[i] = 3'd0;
            if (elig[i]) begin
                if (used < slot_cnt) begin
                    ready[i]    = 1'b1;
                    req_slot[i] = slot[used[1:0]];
                end
                used = used + 3'd1;
            end
        end
    end

    assign req_ready = ready;

    assign rel_hit  = rel_valid && (rel_buf != 3'd0) && (pri_reg[rel_buf] != 3'd0);
    assign rel_err  = rel_valid && !rel_hit;
    assign age_wrap = AGE_EN && (age_reg == AGE_LAST);

    // Aging first, then release and allocation override it; the latter two never share a buffer.
    always_comb begin
        pri_next[0] = 3'd0;
        for (int b = 1; b < 8; b++) begin
            pri_next[b] = pri_reg[b];
            if (age_wrap && (pri_reg[b] != 3'd0) && (pri_reg[b] != 3'd7)) begin
                pri_next[b] = pri_reg[b] + 3'd1;
            end
        end
        if (rel_hit) begin
            pri_next[rel_buf] = 3'd0;
        end
        for (int i = 0; i < 4; i++) begin
            if (ready[i]) begin
                pri_next[req_slot[i]] = req_pri[3*i +: 3];
            end
        end
    end

    always_comb begin
        occ_next = 3'd0;
        for (int b = 1; b < 8; b++) begin
            if (pri_next[b] != 3'd0) begin
                occ_next = occ_next + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 8; b++) begin
                pri_reg[b] <= 3'd0;
            end
            age_reg         <= 8'd0;
            grant_valid_reg <= 4'd0;
            grant_buf_reg   <= 12'd0;
            occ_reg         <= 3'd0;
            err_reg         <= 1'b0;
        end else begin
            for (int b = 0; b < 8; b++) begin
                pri_reg[b] <= pri_next[b];
            end
            age_reg         <= (age_reg == AGE_LAST) ? 8'd0 : age_reg + 8'd1;
            grant_valid_reg <= ready;
            grant_buf_reg   <= grant_buf_next;
            occ_reg         <= occ_next;
            err_reg         <= err_reg | free_err | rel_err;
        end
    end

    assign grant_valid = grant_valid_reg;
    assign grant_buf   = grant_buf_reg;
    assign occ_count   = occ_reg;
    assign err         = err_reg;
    assign pri1        = pri_reg[1];
    assign pri2        = pri_reg[2];
    assign pri3        = pri_reg[3];
    assign pri4        = pri_reg[4];
    assign pri5        = pri_reg[5];
    assign pri6        = pri_reg[6];
    assign pri7        = pri_reg[7];

endmodule

// File: tb/tb_buf_alloc.sv
// Directed and randomized bench for buf_alloc, checked against a table-level reference model.
module tb_buf_alloc;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  free1, free2, free3, free4;
    logic [3:0]  req_valid;
    logic [11:0] req_pri;
    logic [3:0]  req_ready;
    logic [3:0]  grant_valid;
    logic [11:0] grant_buf;
    logic        rel_valid;
    logic [2:0]  rel_buf;
    logic [2:0]  pri1, pri2, pri3, pri4, pri5, pri6, pri7;
    logic [2:0]  occ_count;
    logic        err;

    always #5 clk = ~clk;

    buf_alloc #(.AGE_PERIOD(P), .AGE_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .free1(free1), .free2(free2), .free3(free3), .free4(free4),
        .req_valid(req_valid), .req_pri(req_pri), .req_ready(req_ready),
        .grant_valid(grant_valid), .grant_buf(grant_buf),
        .rel_valid(rel_valid), .rel_buf(rel_buf),
        .pri1(pri1), .pri2(pri2), .pri3(pri3), .pri4(pri4),
        .pri5(pri5), .pri6(pri6), .pri7(pri7),
        .occ_count(occ_count), .err(err)
    );

    int   m_pri [8];
    int   m_cyc;
    logic m_err;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2:0] dut_pri(input int b);
        case (b)
            1: return pri1;
            2: return pri2;
            3: return pri3;
            4: return pri4;
            5: return pri5;
            6: return pri6;
            7: return pri7;
            default: return 3'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 8; b++) m_pri[b] = 0;
        m_cyc = 0;
        m_err = 1'b0;
    endtask

    task automatic check_table(input string tag);
        int occ;
        occ = 0;
        for (int b = 1; b < 8; b++) begin
            check($sformatf("%s pri%0d", tag, b), 12'(dut_pri(b)), 12'(m_pri[b]));
            if (m_pri[b] != 0) occ++;
        end
        check({tag, " occ"}, 12'(occ_count), 12'(occ));
        check({tag, " err"}, 12'(err), 12'(m_err));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " gv"}, 12'(grant_valid), 12'd0);
        check({tag, " gb"}, grant_buf, 12'd0);
        check_table(tag);
    endtask

    // One clock: inputs are already driven; check ready mid-cycle, then registered state after the edge.
    task automatic step(input string tag);
        int          fa [4];
        int          usable [$];
        int          nw [8];
        int          idx;
        int          pr;
        bit          dup;
        logic [3:0]  e_ready;
        logic [11:0] e_gbuf;
        fa[0] = free1; fa[1] = free2; fa[2] = free3; fa[3] = free4;
        @(negedge clk);
        usable.delete();
        for (int n = 0; n < 4; n++) begin
            if (fa[n] == 0) continue;
            dup = 1'b0;
            foreach (usable[u]) if (usable[u] == fa[n]) dup = 1'b1;
            if (m_pri[fa[n]] != 0 || dup) m_err = 1'b1;
            else usable.push_back(fa[n]);
        end
        e_ready = 4'd0;
        e_gbuf  = 12'd0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            pr = int'(req_pri[3*i +: 3]);
            if (req_valid[i] && pr != 0) begin
                if (idx < usable.size()) begin
                    e_ready[i] = 1'b1;
                    e_gbuf[3*i +: 3] = 3'(usable[idx]);
                end
                idx++;
            end
        end
        check({tag, " ready"}, 12'(req_ready), 12'(e_ready));
        nw = m_pri;
        if ((m_cyc % P) == P - 1) begin
            for (int b = 1; b < 8; b++) if (m_pri[b] != 0) nw[b] = (m_pri[b] >= 7) ? 7 : m_pri[b] + 1;
        end
        if (rel_valid) begin
            if (rel_buf == 3'd0 || m_pri[rel_buf] == 0) m_err = 1'b1;
            else nw[rel_buf] = 0;
        end
        for (int i = 0; i < 4; i++) if (e_ready[i]) nw[e_gbuf[3*i +: 3]] = int'(req_pri[3*i +: 3]);
        m_pri = nw;
        m_cyc++;
        @(posedge clk);
        #1;
        check({tag, " gv"}, 12'(grant_valid), 12'(e_ready));
        check({tag, " gb"}, grant_buf, e_gbuf);
        check_table(tag);
    endtask

    task automatic idle();
        free1 = 3'd0; free2 = 3'd0; free3 = 3'd0; free4 = 3'd0;
        req_valid = 4'd0; req_pri = 12'd0;
        rel_valid = 1'b0; rel_buf = 3'd0;
    endtask

    task automatic clean_random(input int s);
        int fl [$];
        int ol [$];
        int rot;
        int k;
        logic [2:0] fv [4];
        fl.delete(); ol.delete();
        for (int b = 1; b < 8; b++) begin
            if (m_pri[b] == 0) fl.push_back(b);
            else ol.push_back(b);
        end
        rot = (fl.size() > 0) ? int'($urandom_range(0, fl.size() - 1)) : 0;
        k = 0;
        for (int n = 0; n < 4; n++) begin
            fv[n] = 3'd0;
            if (k < fl.size() && $urandom_range(0, 3) != 0) begin
                fv[n] = 3'(fl[(rot + k) % fl.size()]);
                k++;
            end
        end
        free1 = fv[0]; free2 = fv[1]; free3 = fv[2]; free4 = fv[3];
        req_valid = 4'($urandom);
        req_pri   = 12'($urandom);
        if (ol.size() > 0 && $urandom_range(0, 2) == 0) begin
            rel_valid = 1'b1;
            rel_buf   = 3'(ol[$urandom_range(0, ol.size() - 1)]);
        end else begin
            rel_valid = 1'b0;
            rel_buf   = 3'($urandom);
        end
        step($sformatf("rnd%0d", s));
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        free1 = 3'd1; free2 = 3'd2; free3 = 3'd3; free4 = 3'd4;
        req_valid = 4'b1111;
        req_pri = {3'd1, 3'd7, 3'd3, 3'd5};
        step("t1");
        check("t1 pri3 direct", 12'(pri3), 12'd7);

        free1 = 3'd0; free2 = 3'd6; free3 = 3'd0; free4 = 3'd7;
        req_valid = 4'b1101;
        req_pri = {3'd6, 3'd4, 3'd0, 3'd2};
        step("t2");
        check("t2 gv direct", 12'(grant_valid), 12'b0101);

        idle();
        free1 = 3'd5; req_valid = 4'b0001; req_pri = 12'd3;
        step("fill");

        idle();
        rel_valid = 1'b1; rel_buf = 3'd3;
        req_valid = 4'b1000; req_pri = {3'd4, 9'd0};
        step("t3");
        check("t3 occ direct", 12'(occ_count), 12'd6);

        for (int s = 0; s < 120; s++) clean_random(s);

        idle();
        rel_valid = 1'b1; rel_buf = 3'd5;
        req_valid = 4'b0000;
        step("rel5a");
        step("rel5b");
        check("t4 err direct", 12'(err), 12'd1);
        idle();
        step("hold0");
        step("hold1");

        for (int s = 0; s < 60; s++) begin
            free1 = 3'($urandom); free2 = 3'($urandom);
            free3 = 3'($urandom); free4 = 3'($urandom);
            req_valid = 4'($urandom); req_pri = 12'($urandom);
            rel_valid = 1'($urandom); rel_buf = 3'($urandom);
            step($sformatf("dirty%0d", s));
        end

        idle();
        free1 = 3'd0; free2 = 3'd0; free3 = 3'd0; free4 = 3'd0;
        req_valid = 4'b1111; req_pri = {3'd1, 3'd2, 3'd3, 3'd4};
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("midrst");
        @(posedge clk); #1;
        check_zero("inrst");
        idle();
        rst_n = 1'b1;

        free1 = 3'd2; req_valid = 4'b0001; req_pri = 12'd6;
        step("age_alloc");
        idle();
        for (int s = 0; s < 8; s++) step($sformatf("age%0d", s));
        check("age pri2 sat", 12'(pri2), 12'd7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
